// File: rtl/ps2_teclado_tx.sv
// rtl/ps2_teclado_tx.sv - PS/2 host-to-keyboard command byte transmitter (optional watchdog: PS2_TX_TIMEOUT_EN)
module ps2_teclado_tx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_MS  = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int INHIBIT_CYCLES = (CLK_FREQ_HZ / 1_000_000) * INHIBIT_US;
  localparam int INH_W          = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_PARITY    = 3'd4;
  localparam logic [2:0] ST_STOP      = 3'd5;
  localparam logic [2:0] ST_ACK       = 3'd6;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd7;

  // A zero-length inhibit or watchdog makes no sense; refuse to elaborate.
  if (INHIBIT_CYCLES < 1 || TIMEOUT_MS < 1) begin : g_param_check
    $error("ps2_teclado_tx: INHIBIT_US and TIMEOUT_MS must yield at least one cycle");
  end

  logic [2:0]       state;
  logic [7:0]       data_reg;
  logic             parity;
  logic [2:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic             ack_ok;
  logic             clk_s1, clk_s2, clk_s3;
  logic             data_s1, data_s2;
  logic             clk_fall;
  logic             wd_expire;

  // Two-flop synchronizers plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  assign clk_fall = clk_s3 & ~clk_s2;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = (CLK_FREQ_HZ / 1000) * TIMEOUT_MS;
  localparam int TMO_W          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] wd_cnt;
  logic             wd_active;

  assign wd_active = (state == ST_START) || (state == ST_DATA) || (state == ST_PARITY) ||
                     (state == ST_STOP)  || (state == ST_ACK);

  // Watchdog: cycles since the last device clock edge while the device owns the clock.
  always_ff @(posedge clk) begin
    if (reset || !wd_active || clk_fall) begin
      wd_cnt <= '0;
    end else if (wd_cnt != TMO_LAST) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_expire = wd_active && !clk_fall && (wd_cnt == TMO_LAST);
`else
  assign wd_expire = 1'b0;
`endif

  // Transfer sequencer; line enables and status are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      data_reg    <= 8'h00;
      parity      <= 1'b0;
      bit_cnt     <= 3'd0;
      inh_cnt     <= '0;
      ack_ok      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_start) begin
            data_reg    <= tx_data;
            parity      <= ~^tx_data;
            inh_cnt     <= '0;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
            tx_busy     <= 1'b1;
            state       <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            state       <= ST_START;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        ST_START: begin
          if (clk_fall) begin
            ps2_data_oe <= ~data_reg[0];
            bit_cnt     <= 3'd0;
            state       <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (clk_fall) begin
            if (bit_cnt == 3'd7) begin
              ps2_data_oe <= ~parity;
              state       <= ST_PARITY;
            end else begin
              bit_cnt     <= bit_cnt + 3'd1;
              ps2_data_oe <= ~data_reg[bit_cnt + 3'd1];
            end
          end
        end
        ST_PARITY: begin
          if (clk_fall) begin
            ps2_data_oe <= 1'b0;
            state       <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (clk_fall) state <= ST_ACK;
        end
        ST_ACK: begin
          if (clk_fall) begin
            ack_ok <= ~data_s2;
            state  <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (clk_s2 && data_s2) begin
            tx_done  <= ack_ok;
            tx_error <= ~ack_ok;
            tx_busy  <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          tx_busy     <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
      if (wd_expire) begin
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        tx_busy     <= 1'b0;
        tx_done     <= 1'b0;
        tx_error    <= 1'b1;
        state       <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ps2_teclado_tx.sv
// tb/tb_ps2_teclado_tx.sv - scoreboard bench for ps2_teclado_tx with a PS/2 keyboard model
module tb_ps2_teclado_tx;

  localparam int CLK_FREQ_HZ = 50_000_000;
  localparam int INHIBIT_US  = 100;
  localparam int TIMEOUT_MS  = 15;
  localparam int INH_CYCLES  = (CLK_FREQ_HZ / 1_000_000) * INHIBIT_US;
  localparam int TMO_CYCLES  = TIMEOUT_MS * (CLK_FREQ_HZ / 1000);
  localparam int HALF        = 12;

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         has_frame;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;
  logic       ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error;

  assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_line = dev_data & ~ps2_data_oe;

  ps2_teclado_tx #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .INHIBIT_US (INHIBIT_US),
    .TIMEOUT_MS (TIMEOUT_MS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .ps2_clk    (ps2_clk_line),
    .ps2_data   (ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [10:0] frame_q[$];
  bit          dev_ack = 1'b1;
  int          dev_stop_at = 0;
  bit          dev_abort = 1'b0;
  int          dev_falls = 0;
  longint      cyc = 0;
  longint      last_fall_cyc = 0;
  int          inh_cnt = 0;
  exp_t        mon_e;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Frame as the keyboard should see it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    f = '0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic half();
    repeat (HALF) @(posedge clk);
    #2;
  endtask

  // Keyboard model: samples each bit while its clock is high, then pulls clock low.
  task automatic dev_run();
    logic [10:0] fr;
    fr = '0;
    for (int i = 0; i < 12; i++) begin
      if (i == 11) dev_data = !dev_ack;
      half();
      if (dev_abort || (dev_stop_at != 0 && i == dev_stop_at)) begin
        dev_clk   = 1'b1;
        dev_data  = 1'b1;
        dev_abort = 1'b0;
        return;
      end
      if (i < 11) fr[i] = ps2_data_line;
      dev_clk = 1'b0;
      dev_falls++;
      last_fall_cyc = cyc;
      half();
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
    frame_q.push_back(fr);
  endtask

  initial begin
    forever begin
      @(posedge ps2_clk_oe);
      @(negedge ps2_clk_oe);
      dev_run();
    end
  end

  // Monitor: pops an expectation whenever a done/error pulse appears; times the inhibit.
  always @(negedge clk) begin
    if (tx_done || tx_error) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual done=%0d error=%0d required none", tx_done, tx_error);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_pulse", tx_done, mon_e.ack);
        check("error_pulse", tx_error, !mon_e.ack);
        check("busy_drop_with_pulse", tx_busy, 0);
        check("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
        if (mon_e.has_frame) begin
          if (frame_q.size() == 0) check("frame_present", 0, 1);
          else check("frame_bits", frame_q.pop_front(), exp_frame(mon_e.data));
        end else begin
          check("timeout_window", ((cyc - last_fall_cyc) >= TMO_CYCLES) &&
                                  ((cyc - last_fall_cyc) <= TMO_CYCLES + 6), 1);
        end
      end
    end
    if (ps2_clk_oe) begin
      inh_cnt++;
    end else if (inh_cnt != 0) begin
      check("inhibit_len", inh_cnt, INH_CYCLES);
      inh_cnt = 0;
    end
  end

  task automatic start_tx(input logic [7:0] d, input bit ack, input bit expect_result, input bit has_frame);
    int guard;
    exp_t e;
    guard = 0;
    while (tx_busy && guard < 20000) begin
      tick();
      guard++;
    end
    dev_ack  = ack;
    tx_data  = d;
    tx_start = 1'b1;
    if (expect_result) begin
      e.data = d;
      e.ack = ack;
      e.has_frame = has_frame;
      exp_q.push_back(e);
    end
    tick();
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    check("busy_rise", tx_busy, 1);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (tx_busy && n < limit) begin
      tick();
      n++;
    end
    check("complete_in_time", tx_busy, 0);
    repeat (3) tick();
  endtask

  task automatic wait_falls(input int target);
    int n;
    n = 0;
    while (dev_falls < target && n < 20000) begin
      tick();
      n++;
    end
    check("device_falls_reached", dev_falls >= target, 1);
  endtask

  initial begin
    int base;
    logic [7:0] rb;
    repeat (3) tick();
    check("reset_outputs", {ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error}, 0);
    reset = 1'b0;
    repeat (5) tick();

    // Known command bytes with a well-behaved keyboard.
    start_tx(8'hED, 1'b1, 1'b1, 1'b1);
    wait_idle(20000);
    start_tx(8'hF4, 1'b1, 1'b1, 1'b1);
    wait_idle(20000);

    // Keyboard withholds the ACK.
    start_tx(8'($urandom), 1'b0, 1'b1, 1'b1);
    wait_idle(20000);

    // Reset in the middle of the data bits, then a clean 0x00.
    base = dev_falls;
    start_tx(8'h5A, 1'b1, 1'b0, 1'b0);
    wait_falls(base + 5);
    reset = 1'b1;
    dev_abort = 1'b1;
    tick();
    check("reset_mid_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("reset_mid_busy", tx_busy, 0);
    reset = 1'b0;
    repeat (4 * HALF) tick();
    dev_abort = 1'b0;
    start_tx(8'h00, 1'b1, 1'b1, 1'b1);
    wait_idle(20000);

    // Extra requests while busy are ignored.
    base = dev_falls;
    start_tx(8'hA7, 1'b1, 1'b1, 1'b1);
    repeat (100) tick();
    tx_data = 8'h3C;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    wait_falls(base + 3);
    tx_data = 8'hC3;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    wait_idle(20000);
    check("no_restart_after_busy", tx_busy, 0);

    // Reset wins over a simultaneous request.
    reset = 1'b1;
    tx_start = 1'b1;
    tx_data = 8'h11;
    tick();
    reset = 1'b0;
    tx_start = 1'b0;
    check("reset_priority_busy", tx_busy, 0);
    tick();
    check("reset_priority_clk_oe", ps2_clk_oe, 0);

    // Randomized bytes and ACK behaviour.
    for (int k = 0; k < 4; k++) begin
      rb = 8'($urandom);
      start_tx(rb, ($urandom_range(0, 3) != 0), 1'b1, 1'b1);
      wait_idle(20000);
    end

`ifdef PS2_TX_TIMEOUT_EN
    // Keyboard stops clocking partway through the data bits.
    dev_stop_at = 5;
    start_tx(8'($urandom), 1'b0, 1'b1, 1'b0);
    wait_idle(TMO_CYCLES + 20000);
    dev_stop_at = 0;
`endif

    repeat (20) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    check("frames_drained", frame_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_teclado_tx.md
PS2_TECLADO_TX -- requirements
Module: ps2_teclado_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50_000_000: system clock frequency.
REQ-002 SHALL have parameter INHIBIT_US, default 100: clock-inhibit duration before the start bit.
REQ-003 SHALL have parameter TIMEOUT_MS, default 15: device-clocking watchdog limit, used only with PS2_TX_TIMEOUT_EN.
REQ-004 SHALL have port clk  input  1: system clock; single clock domain.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port tx_data  input  8: command byte to send to the keyboard.
REQ-007 SHALL have port tx_start  input  1: request strobe, sampled on each clk rising edge.
REQ-008 SHALL have port ps2_clk  input  1: raw PS/2 clock line, asynchronous.
REQ-009 SHALL have port ps2_data  input  1: raw PS/2 data line, asynchronous.
REQ-010 SHALL have port ps2_clk_oe  output  1: 1 drives the clock line low; 0 releases it.
REQ-011 SHALL have port ps2_data_oe  output  1: 1 drives the data line low; 0 releases it.
REQ-012 SHALL have port tx_busy  output  1: a transfer is in progress.
REQ-013 SHALL have port tx_done  output  1: one-cycle pulse when the device ACK is received.
REQ-014 SHALL have port tx_error  output  1: one-cycle pulse on missing ACK or timeout.

Function
REQ-015 SHALL pass ps2_clk and ps2_data each through a 2-FF synchronizer; a falling edge is a synchronized 1->0 transition, flagged for one cycle.
REQ-016 SHALL implement the states IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, WAIT_IDLE.
REQ-017 IDLE: tx_start=1 SHALL latch tx_data, compute odd parity (~^tx_data), and enter INHIBIT; tx_busy SHALL be 1 from the next cycle.
REQ-018 tx_start while tx_busy=1 SHALL be ignored; a one-cycle tx_start SHALL be sufficient.
REQ-019 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for INHIBIT_CYCLES = CLK_FREQ_HZ/1_000_000*INHIBIT_US cycles, then go to START.
REQ-020 START: ps2_clk_oe=0 and ps2_data_oe=1 (start bit 0); the first falling edge SHALL go to DATA and drive bit0.
REQ-021 DATA: on each falling edge, drive the next bit, LSB first; ps2_data_oe=~bit; a 3-bit counter runs 0..7; the falling edge after bit7 SHALL go to PARITY.
REQ-022 PARITY: drive the parity bit; the next falling edge SHALL go to STOP with ps2_data_oe=0 (stop bit 1).
REQ-023 STOP: the next falling edge SHALL go to ACK.
REQ-024 ACK: sample synchronized ps2_data on the next falling edge; 0 means ACK and a pending tx_done; 1 means a pending tx_error; then go to WAIT_IDLE.
REQ-025 WAIT_IDLE: once both synchronized lines are 1, pulse tx_done or tx_error for one cycle, drop tx_busy in that same cycle, and return to IDLE.
REQ-026 Outside INHIBIT and the data-driving states, both *_oe outputs SHALL be 0; both are registered outputs.

Reset
REQ-027 reset=1 SHALL force IDLE with ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0, tx_done=0, tx_error=0, counters 0, and synchronizers to 1.
REQ-028 Reset mid-transfer SHALL release both lines on the next clk edge; no tx_done or tx_error is produced for the aborted byte.
REQ-029 Reset SHALL take priority over tx_start in the same cycle.

Configuration
REQ-030 With PS2_TX_TIMEOUT_EN defined, a watchdog SHALL count TIMEOUT_MS*CLK_FREQ_HZ/1000 cycles from leaving INHIBIT, restarting on each falling edge.
REQ-031 On watchdog expiry before ACK, the block SHALL release both lines, pulse tx_error, and return to IDLE.
REQ-032 Without PS2_TX_TIMEOUT_EN, no watchdog logic SHALL exist, and the block waits indefinitely for device clocks.

Verification
REQ-033 Send tx_data=0xED with the device model clocking and ACKing: data line carries 0,1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulses once; tx_error stays 0.
REQ-034 Send tx_data=0xF4: parity bit 0; ps2_clk_oe is high for exactly 5000 cycles (50 MHz, 100 us); tx_done pulses.
REQ-035 Model leaves data high at the ACK clock: tx_error pulses once; tx_done stays 0; tx_busy falls in the same cycle.
REQ-036 Assert reset after the 4th data falling edge: both oe outputs are 0 next cycle; no done/error pulse; a later 0x00 sends with parity 1.
REQ-037 Pulse tx_start again while busy: no effect; the first byte completes unchanged.
REQ-038 With PS2_TX_TIMEOUT_EN, the model stops clocking after bit 3: tx_error pulses at 750_000 cycles after the last edge; lines are released.
